mem_responder_node: RTL and testbench

Remote-memory responder endpoint on the NoC, the far end of a CPU tile's splitter/collector path. Accepts request flits addressed to this node, reassembles the 4-flit request packet, performs the read or write on a local single-port RAM, and serializes a response packet back to the requester. Sits beside a RAM bank as a memory-only node with no core.

---
 rtl/mem_responder_node.sv | 259 +++++++++++++++++++++++++
 tb/tb_mem_responder_node.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder_node.sv
// mem_responder_node
//   Memory-only NoC endpoint. It collects a 4-flit READ_REQ/WRITE_REQ packet
//   addressed to NODE_ID and performs one access on a local single-port RAM.
//   It then serializes a 4-flit READ_RESP/WRITE_ACK packet back to the sender.
//
//   Build option: define MEM_RESPONDER_WRITE_ACK_EN to answer writes with a
//   WRITE_ACK packet. When it is undefined, writes are posted and only reads
//   produce a response.
//
// Ports
//   clk            single clock, all state on the rising edge
//   rst            synchronous active-high reset
//   collectorReady high while flitIn is being sampled (state RX)
//   flitIn         incoming flit {valid, dest, src, data16, instr, pkt_id, idx}
//   networkReady   network takes flitOut this cycle
//   flitOut        registered outgoing flit, all-zero outside TX
//   ramAddress     RAM word address
//   wrData         RAM write data
//   we             RAM write enable, single-cycle pulse
//   rdData         RAM read data, valid one cycle after ramAddress
//   dropCount      saturating count of dropped flits/packets
//   busy           high outside RX
module mem_responder_node #(
  parameter int NODE_ID         = 0,
  parameter int NODE_COUNT      = 16,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int RAM_SIZE        = 1024,
  localparam int NW             = $clog2(NODE_COUNT),
  localparam int AW             = $clog2(RAM_SIZE),
  localparam int FLIT_W         = 1 + 2*NW + 16 + 3 + PACKET_ID_WIDTH + 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              collectorReady,
  input  logic [FLIT_W-1:0] flitIn,
  input  logic              networkReady,
  output logic [FLIT_W-1:0] flitOut,
  output logic [AW-1:0]     ramAddress,
  output logic [31:0]       wrData,
  output logic              we,
  input  logic [31:0]       rdData,
  output logic [7:0]        dropCount,
  output logic              busy
);

  localparam int PID_LSB   = 2;
  localparam int INSTR_LSB = PID_LSB + PACKET_ID_WIDTH;
  localparam int DATA_LSB  = INSTR_LSB + 3;
  localparam int SRC_LSB   = DATA_LSB + 16;
  localparam int DEST_LSB  = SRC_LSB + NW;

  localparam logic [2:0] READ_REQ  = 3'b001;
  localparam logic [2:0] WRITE_REQ = 3'b010;
  localparam logic [2:0] READ_RESP = 3'b101;
  localparam logic [2:0] WRITE_ACK = 3'b110;

`ifdef MEM_RESPONDER_WRITE_ACK_EN
  localparam bit ACK_WRITES = 1'b1;
`else
  localparam bit ACK_WRITES = 1'b0;
`endif

  localparam logic [NW-1:0] MY_ID = NW'(NODE_ID);

  typedef enum logic [1:0] {
    S_RX,
    S_ACCESS,
    S_WAIT,
    S_TX
  } state_e;

  state_e r_state;
  state_e w_next_state;

  // Packet collection state
  logic                       r_active;
  logic [1:0]                 r_exp_idx;
  logic [NW-1:0]              r_src;
  logic [PACKET_ID_WIDTH-1:0] r_pid;
  logic [2:0]                 r_instr;
  logic [63:0]                r_pkt;

  // Access / response state
  logic [AW-1:0]     r_addr;
  logic [31:0]       r_wrdata;
  logic              r_we;
  logic [63:0]       r_rsp;
  logic [1:0]        r_tx_idx;
  logic [FLIT_W-1:0] r_flit;
  logic [7:0]        r_drop;

  // Incoming flit fields
  logic                       w_in_valid;
  logic [NW-1:0]              w_in_dest;
  logic [NW-1:0]              w_in_src;
  logic [15:0]                w_in_data;
  logic [2:0]                 w_in_instr;
  logic [PACKET_ID_WIDTH-1:0] w_in_pid;
  logic [1:0]                 w_in_idx;

  assign w_in_valid = flitIn[FLIT_W-1];
  assign w_in_dest  = flitIn[DEST_LSB +: NW];
  assign w_in_src   = flitIn[SRC_LSB +: NW];
  assign w_in_data  = flitIn[DATA_LSB +: 16];
  assign w_in_instr = flitIn[INSTR_LSB +: 3];
  assign w_in_pid   = flitIn[PID_LSB +: PACKET_ID_WIDTH];
  assign w_in_idx   = flitIn[1:0];

  logic w_fire, w_to_me, w_start, w_cont_ok, w_last, w_req_ok, w_drop;
  logic w_is_read;

  assign w_fire    = (r_state == S_RX) && w_in_valid;
  assign w_to_me   = (w_in_dest == MY_ID);
  assign w_start   = w_fire && w_to_me && (w_in_idx == 2'd0);
  assign w_cont_ok = w_fire && w_to_me && (w_in_idx != 2'd0) && r_active &&
                     (w_in_idx == r_exp_idx) && (w_in_src == r_src) &&
                     (w_in_pid == r_pid);
  assign w_last    = w_cont_ok && (w_in_idx == 2'd3);
  assign w_req_ok  = w_last && ((r_instr == READ_REQ) || (r_instr == WRITE_REQ));
  // One event per cycle at most: foreign dest, a restart that abandons a
  // partial packet, an out-of-order/mismatched continuation, or a completed
  // packet whose instr is not a request.
  assign w_drop    = w_fire && (!w_to_me || (w_start && r_active) ||
                                ((w_in_idx != 2'd0) && !w_cont_ok) ||
                                (w_last && !w_req_ok));
  assign w_is_read = (r_instr == READ_REQ);

  logic [63:0] w_pkt_next;

  always_comb begin
    w_pkt_next = r_pkt;
    if (w_start) begin
      w_pkt_next[15:0] = w_in_data;
    end else if (w_cont_ok) begin
      w_pkt_next[{r_exp_idx, 4'b0000} +: 16] = w_in_data;
    end
  end

  // Response payload: rdData is only valid during WAIT, so the first flit is
  // built straight from it and the payload is registered for the rest.
  logic [63:0]       w_rsp;
  logic [63:0]       w_tx_src;
  logic [1:0]        w_tx_idx_next;
  logic              w_tx_load;
  logic              w_tx_done;
  logic [FLIT_W-1:0] w_tx_flit;

  assign w_rsp    = {r_pkt[63:32], w_is_read ? rdData : r_pkt[31:0]};
  assign w_tx_src = (r_state == S_WAIT) ? w_rsp : r_rsp;
  assign w_tx_flit = {1'b1, r_src, MY_ID,
                      w_tx_src[{w_tx_idx_next, 4'b0000} +: 16],
                      w_is_read ? READ_RESP : WRITE_ACK,
                      r_pid, w_tx_idx_next};

  always_comb begin
    w_next_state  = r_state;
    w_tx_load     = 1'b0;
    w_tx_done     = 1'b0;
    w_tx_idx_next = r_tx_idx;
    unique case (r_state)
      S_RX: begin
        if (w_req_ok) w_next_state = S_ACCESS;
      end
      S_ACCESS: begin
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (w_is_read || ACK_WRITES) begin
          w_next_state  = S_TX;
          w_tx_load     = 1'b1;
          w_tx_idx_next = 2'd0;
        end else begin
          w_next_state = S_RX;
        end
      end
      S_TX: begin
        if (networkReady) begin
          if (r_tx_idx == 2'd3) begin
            w_next_state = S_RX;
            w_tx_done    = 1'b1;
          end else begin
            w_tx_load     = 1'b1;
            w_tx_idx_next = r_tx_idx + 2'd1;
          end
        end
      end
      default: w_next_state = S_RX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RX;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active  <= 1'b0;
      r_exp_idx <= '0;
      r_src     <= '0;
      r_pid     <= '0;
      r_instr   <= '0;
      r_pkt     <= '0;
      r_addr    <= '0;
      r_wrdata  <= '0;
      r_we      <= 1'b0;
      r_rsp     <= '0;
      r_tx_idx  <= '0;
      r_flit    <= '0;
      r_drop    <= '0;
    end else begin
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;

      if (w_start) begin
        r_active  <= 1'b1;
        r_exp_idx <= 2'd1;
        r_src     <= w_in_src;
        r_pid     <= w_in_pid;
        r_instr   <= w_in_instr;
      end else if (w_cont_ok) begin
        if (w_last) begin
          r_active  <= 1'b0;
          r_exp_idx <= 2'd0;
        end else begin
          r_exp_idx <= r_exp_idx + 2'd1;
        end
      end
      r_pkt <= w_pkt_next;

      // RAM controls are registered at completion so they are valid in ACCESS.
      r_we <= 1'b0;
      if (w_req_ok) begin
        r_addr <= w_pkt_next[32 +: AW];
        if (r_instr == WRITE_REQ) begin
          r_we     <= 1'b1;
          r_wrdata <= w_pkt_next[31:0];
        end
      end

      if (r_state == S_WAIT) r_rsp <= w_rsp;

      if (w_tx_load) begin
        r_flit   <= w_tx_flit;
        r_tx_idx <= w_tx_idx_next;
      end else if (w_tx_done) begin
        r_flit <= '0;
      end
    end
  end

  assign collectorReady = (r_state == S_RX);
  assign busy           = (r_state != S_RX);
  assign flitOut        = r_flit;
  assign ramAddress     = r_addr;
  assign wrData         = r_wrdata;
  assign we             = r_we;
  assign dropCount      = r_drop;

endmodule

// File: tb/tb_mem_responder_node.sv
module tb_mem_responder_node;

  localparam logic [2:0] RD  = 3'b001;
  localparam logic [2:0] WR  = 3'b010;
  localparam logic [2:0] RRS = 3'b101;
  localparam logic [2:0] WAK = 3'b110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        collectorReady;
  logic [34:0] flitIn = '0;
  logic        networkReady = 1'b1;
  logic [34:0] flitOut;
  logic [9:0]  ramAddress;
  logic [31:0] wrData;
  logic        we;
  logic [31:0] rdData = '0;
  logic [7:0]  dropCount;
  logic        busy;

  always #5 clk = ~clk;

  mem_responder_node #(
    .NODE_ID(3),
    .NODE_COUNT(16),
    .PACKET_ID_WIDTH(5),
    .RAM_SIZE(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .collectorReady(collectorReady),
    .flitIn(flitIn),
    .networkReady(networkReady),
    .flitOut(flitOut),
    .ramAddress(ramAddress),
    .wrData(wrData),
    .we(we),
    .rdData(rdData),
    .dropCount(dropCount),
    .busy(busy)
  );

  // RAM model: synchronous read, one-cycle latency.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (we) mem[ramAddress] <= wrData;
    rdData <= mem[ramAddress];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int first_cyc = -1;
  bit prev_v  = 1'b0;

  logic [34:0] sb_flit [$];
  logic [41:0] sb_wr   [$];
  logic [34:0] m_flit;
  logic [41:0] m_wr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] mk_flit(input logic [3:0] dest, input logic [3:0] src,
                                          input logic [15:0] data, input logic [2:0] instr,
                                          input logic [4:0] pid, input logic [1:0] idx);
    return {1'b1, dest, src, data, instr, pid, idx};
  endfunction

  // Output monitor: every flit taken by the network and every RAM write is
  // matched against the scoreboards.
  always @(negedge clk) begin
    if (!rst) begin
      if (flitOut[34] && !prev_v) first_cyc = cyc;
      prev_v = flitOut[34];
      if (flitOut[34] && networkReady) begin
        if (sb_flit.size() == 0) begin
          chk("extra_flit", {29'd0, flitOut}, 64'd0);
        end else begin
          m_flit = sb_flit.pop_front();
          chk("tx_flit", {29'd0, flitOut}, {29'd0, m_flit});
        end
      end
      if (we) begin
        if (sb_wr.size() == 0) begin
          chk("extra_we", {22'd0, ramAddress, wrData}, 64'd0);
        end else begin
          m_wr = sb_wr.pop_front();
          chk("ram_write", {22'd0, ramAddress, wrData}, {22'd0, m_wr});
        end
      end
    end
  end

  // Stimulus is driven just after a rising edge; the flit is held until the
  // DUT is ready, then taken on the following edge.
  task automatic send_flit(input logic [34:0] f);
    int n = 0;
    while (!collectorReady && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("ready_timeout", 64'd0, 64'd1);
    flitIn = f;
    @(posedge clk); #1;
    flitIn = '0;
  endtask

  task automatic send_pkt(input logic [3:0] dest, input logic [3:0] src, input logic [2:0] instr,
                          input logic [4:0] pid, input logic [31:0] addr, input logic [31:0] data);
    logic [63:0] p;
    p = {addr, data};
    for (int k = 0; k < 4; k++)
      send_flit(mk_flit(dest, src, p[k*16 +: 16], instr, pid, 2'(k)));
  endtask

  task automatic push_rsp(input logic [3:0] dest, input logic [2:0] instr, input logic [4:0] pid,
                          input logic [31:0] addr, input logic [31:0] data);
    logic [63:0] p;
    p = {addr, data};
    for (int k = 0; k < 4; k++)
      sb_flit.push_back(mk_flit(dest, 4'd3, p[k*16 +: 16], instr, pid, 2'(k)));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || sb_flit.size() != 0 || sb_wr.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, {63'd0, n < 200}, 64'd1);
  endtask

  task automatic wait_flit_idx(input logic [1:0] k, input string tag);
    int n = 0;
    while (!(flitOut[34] && flitOut[1:0] == k) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, {63'd0, n < 100}, 64'd1);
  endtask

  logic [34:0] snap;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_ready", {63'd0, collectorReady}, 64'd1);
    chk("rst_flit", {29'd0, flitOut}, 64'd0);
    chk("rst_we", {63'd0, we}, 64'd0);
    chk("rst_addr", {54'd0, ramAddress}, 64'd0);
    chk("rst_wrdata", {32'd0, wrData}, 64'd0);
    chk("rst_drop", {56'd0, dropCount}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;

    // Write 0xDEADBEEF to address 16 from node 5, id 7.
    sb_wr.push_back({10'd16, 32'hDEADBEEF});
`ifdef MEM_RESPONDER_WRITE_ACK_EN
    push_rsp(4'd5, WAK, 5'd7, 32'h0000_0010, 32'hDEADBEEF);
`endif
    send_pkt(4'd3, 4'd5, WR, 5'd7, 32'h0000_0010, 32'hDEADBEEF);
    wait_idle("write_done");

    // Read from 0x410 wraps onto word 16.
    push_rsp(4'd5, RRS, 5'd8, 32'h0000_0410, 32'hDEADBEEF);
    first_cyc = -1;
    send_pkt(4'd3, 4'd5, RD, 5'd8, 32'h0000_0410, 32'h0);
    begin
      int t_acc;
      t_acc = cyc;
      wait_idle("read_done");
      chk("read_latency", 64'(first_cyc - t_acc), 64'd2);
    end
    chk("read_ready_after", {63'd0, collectorReady}, 64'd1);
    chk("idle_flit_zero", {29'd0, flitOut}, 64'd0);

    // Flit for another node is dropped with no RAM access.
    send_flit(mk_flit(4'd2, 4'd5, 16'h1234, WR, 5'd1, 2'd0));
    repeat (3) @(posedge clk); #1;
    chk("foreign_drop", {56'd0, dropCount}, 64'd1);
    chk("foreign_busy", {63'd0, busy}, 64'd0);

    // Node 6 continuation in the middle of a node 5 packet is dropped.
    sb_wr.push_back({10'h20, 32'h12345678});
`ifdef MEM_RESPONDER_WRITE_ACK_EN
    push_rsp(4'd5, WAK, 5'd9, 32'h0000_0020, 32'h12345678);
`endif
    send_flit(mk_flit(4'd3, 4'd5, 16'h5678, WR, 5'd9, 2'd0));
    send_flit(mk_flit(4'd3, 4'd6, 16'hAAAA, WR, 5'd9, 2'd1));
    send_flit(mk_flit(4'd3, 4'd5, 16'h1234, WR, 5'd9, 2'd1));
    send_flit(mk_flit(4'd3, 4'd5, 16'h0020, WR, 5'd9, 2'd2));
    send_flit(mk_flit(4'd3, 4'd5, 16'h0000, WR, 5'd9, 2'd3));
    wait_idle("interleave_done");
    chk("interleave_drop", {56'd0, dropCount}, 64'd2);

    // Network stall on response flit 1.
    push_rsp(4'd5, RRS, 5'd10, 32'h0000_0020, 32'h12345678);
    send_pkt(4'd3, 4'd5, RD, 5'd10, 32'h0000_0020, 32'h0);
    wait_flit_idx(2'd1, "stall_reach");
    networkReady = 1'b0;
    snap = flitOut;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_stable", {29'd0, flitOut}, {29'd0, snap});
    end
    @(posedge clk); #1;
    networkReady = 1'b1;
    wait_idle("stall_done");

    // Reset while flit 2 is on the wire.
    push_rsp(4'd5, RRS, 5'd11, 32'h0000_0010, 32'hDEADBEEF);
    void'(sb_flit.pop_back());
    void'(sb_flit.pop_back());
    send_pkt(4'd3, 4'd5, RD, 5'd11, 32'h0000_0010, 32'h0);
    wait_flit_idx(2'd2, "rst_tx_reach");
    networkReady = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    networkReady = 1'b1;
    @(negedge clk);
    chk("midtx_rst_flit", {29'd0, flitOut}, 64'd0);
    chk("midtx_rst_ready", {63'd0, collectorReady}, 64'd1);
    chk("midtx_rst_drop", {56'd0, dropCount}, 64'd0);
    chk("midtx_rst_sb", 64'(sb_flit.size()), 64'd0);
    @(posedge clk); #1;

    // Restart on idx 0 discards the partial packet; the new one completes.
    sb_wr.push_back({10'h30, 32'hCAFEF00D});
`ifdef MEM_RESPONDER_WRITE_ACK_EN
    push_rsp(4'd5, WAK, 5'd12, 32'h0000_0030, 32'hCAFEF00D);
`endif
    send_flit(mk_flit(4'd3, 4'd5, 16'h1111, WR, 5'd4, 2'd0));
    send_pkt(4'd3, 4'd5, WR, 5'd12, 32'h0000_0030, 32'hCAFEF00D);
    wait_idle("restart_done");
    chk("restart_drop", {56'd0, dropCount}, 64'd1);

    // A complete packet with a non-request instr is dropped.
    send_pkt(4'd3, 4'd5, RRS, 5'd13, 32'h0000_0040, 32'h0);
    repeat (4) @(posedge clk); #1;
    chk("nonreq_drop", {56'd0, dropCount}, 64'd2);
    chk("nonreq_busy", {63'd0, busy}, 64'd0);
    chk("final_sb_flit", 64'(sb_flit.size()), 64'd0);
    chk("final_sb_wr", 64'(sb_wr.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
